msk_gf2n_mul_hpc3_pipe: RTL and testbench

- Masked GF(2^N) multiplier gadget built on the HPC3 construction.
- Generalised in share count d, field width N (4 or 8) and reduction polynomial.
- Owns its own `a` pipeline register, so callers no longer supply a delayed copy of `a`.
- Adds a valid/ready handshake with back-pressure and consumes randomness only on accepted transfers.
- Sits in masked S-box datapaths (GF(2^4) tower inversion, GF(2^8) MixColumns/inversion) where stalls from downstream must not corrupt or replay masks.

---
 rtl/msk_gf2n_pkg.sv | 26 ++
 rtl/msk_gf2n_mul_comb.sv | 28 ++
 rtl/msk_gf2n_mul_hpc3_pipe.sv | 166 ++++++++++++++++
 tb/tb_msk_gf2n_mul_hpc3_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_gf2n_pkg.sv
// Shared constants and elaboration helpers for the masked GF(2^N) multiplier gadgets.
package msk_gf2n_pkg;

  localparam logic [3:0] POLY_GF16  = 4'h3;
  localparam logic [7:0] POLY_GF256 = 8'h1B;

  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stage_e;

  function automatic int unsigned hpc3_rnd_bits(input int unsigned d, input int unsigned N);
    return d * (d - 1) * N;
  endfunction

  // Index of the unordered share pair {i,j}; symmetric in i and j.
  function automatic int unsigned pair_index(input int unsigned i, input int unsigned j,
                                             input int unsigned d);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
  endfunction

endpackage

// File: rtl/msk_gf2n_mul_comb.sv
// Combinational GF(2^N) polynomial-basis multiplier, reduction x^N + POLY.
module msk_gf2n_mul_comb
  import msk_gf2n_pkg::*;
#(
  parameter int unsigned  N    = 4,
  parameter logic [N-1:0] POLY = N'(POLY_GF16)
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_p
);

  logic [N-1:0] w_acc;

  // Horner scan from the MSB of y: shift-and-reduce, then conditionally add x.
  always_comb begin
    w_acc = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_acc = {w_acc[N-2:0], 1'b0} ^ (w_acc[N-1] ? POLY : '0);
      if (i_y[N-1-k]) begin
        w_acc = w_acc ^ i_x;
      end
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/msk_gf2n_mul_hpc3_pipe.sv
// HPC3 masked GF(2^N) multiplier, one register stage with valid/ready handshake.
// Optional idle flush of share registers: define MSKG2N_MUL_FLUSH_EN.
module msk_gf2n_mul_hpc3_pipe
  import msk_gf2n_pkg::*;
#(
  parameter int unsigned  d    = 2,
  parameter int unsigned  N    = 4,
  parameter logic [N-1:0] POLY = (N == 8) ? N'(POLY_GF256) : N'(POLY_GF16)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N*d-1:0]                 ina,
  input  logic [N*d-1:0]                 inb,
  input  logic [hpc3_rnd_bits(d,N)-1:0]  rnd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N*d-1:0]                 out
);

  localparam int unsigned NP = d * (d - 1) / 2;
  localparam int unsigned NQ = d * (d - 1);

  if (!(N == 4 || N == 8)) begin : g_bad_n
    $error("msk_gf2n_mul_hpc3_pipe: N must be 4 or 8");
  end
  if (d < 2) begin : g_bad_d
    $error("msk_gf2n_mul_hpc3_pipe: d must be at least 2");
  end

  stage_e       r_state;
  stage_e       w_state_nxt;
  logic         w_fire;

  logic [N-1:0] w_a      [d];
  logic [N-1:0] w_b      [d];
  logic [N-1:0] w_r0     [NP];
  logic [N-1:0] w_r1     [NP];
  logic [N-1:0] w_u_nxt  [NQ];
  logic [N-1:0] w_bm_nxt [NQ];
  logic [N-1:0] w_v      [NQ];
  logic [N-1:0] w_sh_out [d];

  logic [N-1:0] r_a  [d];
  logic [N-1:0] r_u  [NQ];
  logic [N-1:0] r_bm [NQ];

  assign w_fire = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STG_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) begin
      w_state_nxt = STG_FULL;
    end else if (r_state == STG_FULL && out_ready) begin
      w_state_nxt = STG_EMPTY;
    end
  end

  always_comb begin
    out_valid = (r_state == STG_FULL);
    in_ready  = out_ready | (r_state != STG_FULL);
  end

  // Unpack bit-interleaved sharings and split rnd into r0/r1 halves.
  always_comb begin
    w_a  = '{default: '0};
    w_b  = '{default: '0};
    w_r0 = '{default: '0};
    w_r1 = '{default: '0};
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_a[i][k] = ina[k*d + i];
        w_b[i][k] = inb[k*d + i];
      end
    end
    for (int unsigned p = 0; p < NP; p++) begin
      w_r0[p] = rnd[N*p +: N];
      w_r1[p] = rnd[N*(NP + p) +: N];
    end
  end

  for (genvar gi = 0; gi < d; gi++) begin : g_sh
    for (genvar gj2 = 0; gj2 < d - 1; gj2++) begin : g_pr
      localparam int unsigned J = (gj2 < gi) ? gj2 : gj2 + 1;
      localparam int unsigned P = pair_index(gi, J, d);
      localparam int unsigned Q = gi * (d - 1) + gj2;

      logic [N-1:0] w_uy;
      logic [N-1:0] w_uprod;

      // The first partner of each share also carries the a_i*b_i cross term.
      if (gj2 == 0) begin : g_first
        assign w_uy = w_b[gi] ^ w_r0[P];
      end else begin : g_rest
        assign w_uy = w_r0[P];
      end

      msk_gf2n_mul_comb #(.N(N), .POLY(POLY)) u_mul_u (
        .i_x (w_a[gi]),
        .i_y (w_uy),
        .o_p (w_uprod)
      );

      assign w_u_nxt[Q]  = w_uprod ^ w_r1[P];
      assign w_bm_nxt[Q] = w_b[J] ^ w_r0[P];

      msk_gf2n_mul_comb #(.N(N), .POLY(POLY)) u_mul_v (
        .i_x (r_a[gi]),
        .i_y (r_bm[Q]),
        .o_p (w_v[Q])
      );
    end
  end

`ifdef MSKG2N_MUL_FLUSH_EN
  logic w_drain;
  assign w_drain = (r_state == STG_FULL) & out_ready & ~w_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < d; i++) r_a[i] <= '0;
      for (int unsigned q = 0; q < NQ; q++) begin
        r_u[q]  <= '0;
        r_bm[q] <= '0;
      end
    end else if (w_fire) begin
      for (int unsigned i = 0; i < d; i++) r_a[i] <= w_a[i];
      for (int unsigned q = 0; q < NQ; q++) begin
        r_u[q]  <= w_u_nxt[q];
        r_bm[q] <= w_bm_nxt[q];
      end
`ifdef MSKG2N_MUL_FLUSH_EN
    end else if (w_drain) begin
      for (int unsigned i = 0; i < d; i++) r_a[i] <= '0;
      for (int unsigned q = 0; q < NQ; q++) begin
        r_u[q]  <= '0;
        r_bm[q] <= '0;
      end
`endif
    end
  end

  always_comb begin
    w_sh_out = '{default: '0};
    out      = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j2 = 0; j2 < d - 1; j2++) begin
        w_sh_out[i] = w_sh_out[i] ^ r_u[i*(d-1) + j2] ^ w_v[i*(d-1) + j2];
      end
      for (int unsigned k = 0; k < N; k++) begin
        out[k*d + i] = w_sh_out[i][k];
      end
    end
  end

endmodule

// File: tb/tb_msk_gf2n_mul_hpc3_pipe.sv
// Self-checking bench: d=2/N=4 and d=3/N=8 instances against a plain GF multiply model.
module tb_msk_gf2n_mul_hpc3_pipe;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_ina, a_inb, a_rnd, a_out;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_ina, b_inb, b_out;
  logic [47:0] b_rnd;

  msk_gf2n_mul_hpc3_pipe #(.d(2), .N(4), .POLY(4'h3)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .ina       (a_ina),
    .inb       (a_inb),
    .rnd       (a_rnd),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out       (a_out)
  );

  msk_gf2n_mul_hpc3_pipe #(.d(3), .N(8), .POLY(8'h1B)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .ina       (b_ina),
    .inb       (b_inb),
    .rnd       (b_rnd),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out       (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Schoolbook carry-less product followed by long division by x^n + poly.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y,
                                      input int n, input logic [7:0] poly);
    int unsigned prod;
    int unsigned full;
    prod = 0;
    full = (32'd1 << n) | 32'(poly);
    for (int i = 0; i < n; i++) if (y[i]) prod ^= 32'(x) << i;
    for (int b = 2*n - 2; b >= n; b--) if (prod[b]) prod ^= full << (b - n);
    return 8'(prod);
  endfunction

  function automatic logic [23:0] share(input logic [7:0] v, input int d, input int n);
    logic [23:0] r;
    logic [7:0]  s;
    logic [7:0]  acc;
    r   = '0;
    acc = v;
    for (int i = 1; i < d; i++) begin
      s   = 8'($urandom);
      acc ^= s;
      for (int k = 0; k < n; k++) r[k*d + i] = s[k];
    end
    for (int k = 0; k < n; k++) r[k*d] = acc[k];
    return r;
  endfunction

  function automatic logic [7:0] unshare(input logic [23:0] v, input int d, input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < d; i++)
      for (int k = 0; k < n; k++) r[k] ^= v[k*d + i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] x, input logic [3:0] y);
    a_ina      = 8'(share({4'h0, x}, 2, 4));
    a_inb      = 8'(share({4'h0, y}, 2, 4));
    a_rnd      = 8'($urandom);
    a_in_valid = 1'b1;
  endtask

  task automatic drive_b(input logic [7:0] x, input logic [7:0] y);
    b_ina      = share(x, 3, 8);
    b_inb      = share(y, 3, 8);
    b_rnd      = {16'($urandom), $urandom};
    b_in_valid = 1'b1;
  endtask

  logic [3:0]  x4, y4;
  logic [7:0]  x8, y8, m_val;
  logic [7:0]  snap;
  logic        m_valid, m_ready;

  initial begin
    rst_n = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_ina = '0; a_inb = '0; a_rnd = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_ina = '0; b_inb = '0; b_rnd = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out",   32'(a_out),       32'd0);
    check("rst_a_ready", 32'(a_in_ready),  32'd1);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_out",   32'(b_out),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive_a(4'h7, 4'h9);
    tick;
    check("first_valid", 32'(a_out_valid), 32'd1);
    check("mul_7x9", 32'(unshare(24'(a_out), 2, 4)), 32'hA);

    // All 256 operand pairs streamed back to back.
    for (int p = 0; p < 256; p++) begin
      x4 = 4'(p >> 4);
      y4 = 4'(p);
      drive_a(x4, y4);
      tick;
      check("exh_a", {23'd0, a_out_valid, unshare(24'(a_out), 2, 4)},
                     {23'd0, 1'b1, gmul({4'h0, x4}, {4'h0, y4}, 4, 8'h03)});
    end

    snap        = a_out;
    a_out_ready = 1'b0;
    drive_a(4'(($urandom)), 4'($urandom));
    #1 check("bp_ready_low", 32'(a_in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      a_rnd = 8'($urandom);
      a_ina = 8'($urandom);
      a_inb = 8'($urandom);
      tick;
      check("bp_hold", {23'd0, a_out_valid, a_out}, {23'd0, 1'b1, snap});
      check("bp_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    x4 = 4'($urandom);
    y4 = 4'($urandom);
    drive_a(x4, y4);
    #1 check("bp_ready_rel", 32'(a_in_ready), 32'd1);
    tick;
    check("bp_reaccept", {23'd0, a_out_valid, unshare(24'(a_out), 2, 4)},
                         {23'd0, 1'b1, gmul({4'h0, x4}, {4'h0, y4}, 4, 8'h03)});

    snap       = a_out;
    a_in_valid = 1'b0;
    tick;
    check("drain_valid", 32'(a_out_valid), 32'd0);
`ifdef MSKG2N_MUL_FLUSH_EN
    check("drain_out", 32'(a_out), 32'd0);
`else
    check("drain_out", 32'(a_out), 32'(snap));
`endif
    tick;
    check("idle_ready", 32'(a_in_ready), 32'd1);

    // Random valid/ready traffic against a one-slot model.
    m_valid = 1'b0;
    m_val   = '0;
    for (int c = 0; c < 80; c++) begin
      x4 = 4'($urandom);
      y4 = 4'($urandom);
      drive_a(x4, y4);
      a_in_valid  = ($urandom_range(0, 2) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      m_ready     = a_out_ready | ~m_valid;
      #1 check("rnd_ready", 32'(a_in_ready), 32'(m_ready));
      if (a_in_valid && m_ready) begin
        m_valid = 1'b1;
        m_val   = gmul({4'h0, x4}, {4'h0, y4}, 4, 8'h03);
      end else if (a_out_ready) begin
        m_valid = 1'b0;
      end
      tick;
      check("rnd_valid", 32'(a_out_valid), 32'(m_valid));
      if (m_valid) check("rnd_data", 32'(unshare(24'(a_out), 2, 4)), 32'(m_val));
    end

    a_out_ready = 1'b1;
    drive_a(4'h3, 4'h5);
    tick;
    check("pre_rst_valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_out",   32'(a_out),       32'd0);
    check("mid_rst_ready", 32'(a_in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(4'hB, 4'hE);
    tick;
    check("post_rst", {23'd0, a_out_valid, unshare(24'(a_out), 2, 4)},
                      {23'd0, 1'b1, gmul(8'h0B, 8'h0E, 4, 8'h03)});
    a_in_valid = 1'b0;

    drive_b(8'h57, 8'h83);
    tick;
    check("b_57x83", {23'd0, b_out_valid, unshare(b_out, 3, 8)}, {23'd0, 1'b1, 8'hC1});
    drive_b(8'h00, 8'hFF);
    tick;
    check("b_00xFF", {23'd0, b_out_valid, unshare(b_out, 3, 8)}, {23'd0, 1'b1, 8'h00});
    for (int c = 0; c < 16; c++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      drive_b(x8, y8);
      tick;
      check("b_stream", {23'd0, b_out_valid, unshare(b_out, 3, 8)},
                        {23'd0, 1'b1, gmul(x8, y8, 8, 8'h1B)});
    end
    b_in_valid = 1'b0;
    tick;
    check("b_drain_valid", 32'(b_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
